// File: rtl/fetch_stage_pkg.sv
// Shared constants and state encoding for the instruction fetch stage.
package fetch_stage_pkg;

    localparam int unsigned BITS_DEFAULT  = 64;
    localparam int unsigned DEPTH_DEFAULT = 2;
    localparam int unsigned ILEN          = 32;
    localparam int unsigned INSTR_STEP    = 4;

    typedef enum logic [1:0] {
        ST_FETCH = 2'd0,
        ST_WAIT  = 2'd1,
        ST_DROP  = 2'd2
    } fetch_state_e;

endpackage

// File: rtl/fetch_fifo.sv
// Fetch buffer: DEPTH-entry FIFO of {pc, instr} with synchronous flush.
module fetch_fifo #(
    parameter int unsigned WIDTH = 96,
    parameter int unsigned DEPTH = 2
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             push_i,
    input  logic [WIDTH-1:0]                 push_data_i,
    input  logic                             pop_i,
    input  logic                             flush_i,
    output logic [WIDTH-1:0]                 head_o,
    output logic [$clog2(DEPTH+1)-1:0]       count_o
);

    localparam int unsigned CNT_W = $clog2(DEPTH + 1);
    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [CNT_W-1:0] count_q;
    logic             do_push;
    logic             do_pop;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    assign do_pop  = pop_i && (count_q != '0);
    // A push into a full buffer is only legal when the head leaves in the same cycle.
    assign do_push = push_i && ((count_q != CNT_W'(DEPTH)) || do_pop);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else if (flush_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) begin
                mem_q[wr_ptr_q] <= push_data_i;
                wr_ptr_q        <= ptr_inc(wr_ptr_q);
            end
            if (do_pop) begin
                rd_ptr_q <= ptr_inc(rd_ptr_q);
            end
            if (do_push && !do_pop) begin
                count_q <= count_q + CNT_W'(1);
            end else if (do_pop && !do_push) begin
                count_q <= count_q - CNT_W'(1);
            end
        end
    end

    assign head_o  = mem_q[rd_ptr_q];
    assign count_o = count_q;

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch: PC sequencing, single-outstanding memory request FSM,
// redirect flush and a small decode-facing buffer.
module fetch_stage
    import fetch_stage_pkg::*;
#(
    parameter int unsigned BITS  = BITS_DEFAULT,
    parameter int unsigned DEPTH = DEPTH_DEFAULT
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [BITS-1:0] pc_in,
    output logic            pc_load,
    output logic [BITS-1:0] pc_next,
    input  logic            redirect,
    input  logic [BITS-1:0] redirect_target,
    output logic            mem_req_valid,
    input  logic            mem_req_ready,
    output logic [BITS-1:0] mem_req_addr,
    input  logic            mem_rsp_valid,
    input  logic [31:0]     mem_rsp_data,
    output logic            id_valid,
    input  logic            id_ready,
    output logic [31:0]     id_instr,
    output logic [BITS-1:0] id_pc
);

    localparam int unsigned CNT_W = $clog2(DEPTH + 1);
    localparam int unsigned SUM_W = CNT_W + 1;
    localparam int unsigned ENT_W = BITS + ILEN;

    fetch_state_e    state_q;
    fetch_state_e    state_d;
    logic [BITS-1:0] inflight_pc_q;
    logic [BITS-1:0] inflight_pc_d;
    logic [CNT_W-1:0] count;
    logic [ENT_W-1:0] head;
    logic            outstanding_c;
    logic            req_hs_c;
    logic            push_c;
    logic            pop_c;

    assign outstanding_c = (state_q != ST_FETCH);
    assign mem_req_addr  = {pc_in[BITS-1:2], 2'b00};
    assign pop_c         = id_valid && id_ready;

    // Next state, request handshake and PC update selection.
    always_comb begin
        state_d       = state_q;
        inflight_pc_d = inflight_pc_q;
        mem_req_valid = 1'b0;
        req_hs_c      = 1'b0;
        push_c        = 1'b0;
        pc_load       = 1'b0;
        pc_next       = pc_in + BITS'(INSTR_STEP);

        case (state_q)
            ST_FETCH: begin
                mem_req_valid = rst_n && !redirect &&
                                ((SUM_W'(count) + SUM_W'(outstanding_c)) < SUM_W'(DEPTH));
                req_hs_c      = mem_req_valid && mem_req_ready;
                if (req_hs_c) begin
                    state_d       = ST_WAIT;
                    inflight_pc_d = pc_in;
                end
            end
            ST_WAIT: begin
                if (mem_rsp_valid) begin
                    state_d = ST_FETCH;
                    push_c  = !redirect;
                end else if (redirect) begin
                    state_d = ST_DROP;
                end
            end
            ST_DROP: begin
                if (mem_rsp_valid) begin
                    state_d = ST_FETCH;
                end
            end
            default: begin
                state_d = ST_FETCH;
            end
        endcase

        if (redirect) begin
            pc_load = rst_n;
            pc_next = redirect_target;
        end else if (req_hs_c) begin
            pc_load = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ST_FETCH;
            inflight_pc_q <= '0;
        end else begin
            state_q       <= state_d;
            inflight_pc_q <= inflight_pc_d;
        end
    end

    fetch_fifo #(
        .WIDTH (ENT_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk         (clk),
        .rst_n       (rst_n),
        .push_i      (push_c),
        .push_data_i ({inflight_pc_q, mem_rsp_data}),
        .pop_i       (pop_c),
        .flush_i     (redirect),
        .head_o      (head),
        .count_o     (count)
    );

    assign id_valid = (count != '0);
    assign id_instr = head[ILEN-1:0];
    assign id_pc    = head[ENT_W-1:ILEN];

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage with a queue-based reference model checked every cycle.
module tb_fetch_stage;

    localparam int unsigned BITS  = 64;
    localparam int unsigned DEPTH = 2;

    logic            clk = 1'b0;
    logic            rst_n;
    logic [BITS-1:0] pc_in;
    logic            pc_load;
    logic [BITS-1:0] pc_next;
    logic            redirect;
    logic [BITS-1:0] redirect_target;
    logic            mem_req_valid;
    logic            mem_req_ready;
    logic [BITS-1:0] mem_req_addr;
    logic            mem_rsp_valid;
    logic [31:0]     mem_rsp_data;
    logic            id_valid;
    logic            id_ready;
    logic [31:0]     id_instr;
    logic [BITS-1:0] id_pc;

    fetch_stage #(.BITS(BITS), .DEPTH(DEPTH)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .pc_in           (pc_in),
        .pc_load         (pc_load),
        .pc_next         (pc_next),
        .redirect        (redirect),
        .redirect_target (redirect_target),
        .mem_req_valid   (mem_req_valid),
        .mem_req_ready   (mem_req_ready),
        .mem_req_addr    (mem_req_addr),
        .mem_rsp_valid   (mem_rsp_valid),
        .mem_rsp_data    (mem_rsp_data),
        .id_valid        (id_valid),
        .id_ready        (id_ready),
        .id_instr        (id_instr),
        .id_pc           (id_pc)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at t=%0t", name, act, exp, $time);
        end
    endtask

    // Reference model: buffered entries plus the fate of the one pending request
    // (0 = none, 1 = live, 2 = will be discarded).
    logic [63:0] m_pc[$];
    logic [31:0] m_ins[$];
    int          m_pend    = 0;
    logic [63:0] m_pend_pc = '0;
    logic        e_rv, e_hs, e_ld, e_pop;

    function automatic void model_reset();
        m_pc.delete();
        m_ins.delete();
        m_pend    = 0;
        m_pend_pc = '0;
    endfunction

    initial begin
        forever begin
            @(negedge clk);
            #3;
            if (!rst_n) model_reset();
            e_rv = rst_n && (m_pend == 0) && (m_pc.size() < int'(DEPTH)) && !redirect;
            e_hs = e_rv && mem_req_ready;
            e_ld = rst_n && (redirect || e_hs);
            chk("m.req_valid", 64'(mem_req_valid), 64'(e_rv));
            if (e_rv) chk("m.req_addr", mem_req_addr, pc_in & ~64'h3);
            chk("m.pc_load", 64'(pc_load), 64'(e_ld));
            if (e_ld) chk("m.pc_next", pc_next, redirect ? redirect_target : pc_in + 64'd4);
            chk("m.id_valid", 64'(id_valid), 64'(m_pc.size() != 0));
            if (m_pc.size() != 0) begin
                chk("m.id_pc", id_pc, m_pc[0]);
                chk("m.id_instr", 64'(id_instr), 64'(m_ins[0]));
            end else if (!rst_n) begin
                chk("m.rst_id_pc", id_pc, 64'h0);
                chk("m.rst_id_instr", 64'(id_instr), 64'h0);
            end
            @(posedge clk);
            if (!rst_n) begin
                model_reset();
            end else begin
                e_pop = (m_pc.size() != 0) && id_ready;
                if (redirect) begin
                    m_pc.delete();
                    m_ins.delete();
                    m_pend = (m_pend != 0 && !mem_rsp_valid) ? 2 : 0;
                end else begin
                    if (e_pop) begin
                        void'(m_pc.pop_front());
                        void'(m_ins.pop_front());
                    end
                    if (m_pend == 1 && mem_rsp_valid) begin
                        m_pc.push_back(m_pend_pc);
                        m_ins.push_back(mem_rsp_data);
                        m_pend = 0;
                    end else if (m_pend == 2 && mem_rsp_valid) begin
                        m_pend = 0;
                    end else if (e_hs) begin
                        m_pend    = 1;
                        m_pend_pc = pc_in;
                    end
                end
            end
        end
    end

    task automatic drv(input logic [63:0] pc, input logic rdy, input logic rv,
                       input logic [31:0] rd, input logic ir, input logic rdir,
                       input logic [63:0] tgt);
        pc_in           = pc;
        mem_req_ready   = rdy;
        mem_rsp_valid   = rv;
        mem_rsp_data    = rd;
        id_ready        = ir;
        redirect        = rdir;
        redirect_target = tgt;
    endtask

    task automatic nxt();
        @(negedge clk);
    endtask

    initial begin
        rst_n = 1'b0;
        drv(64'h1000, 1'b1, 1'b0, 32'h0, 1'b1, 1'b0, 64'h0);
        nxt();
        #2;
        chk("rst.req_valid", 64'(mem_req_valid), 64'd0);
        chk("rst.pc_load", 64'(pc_load), 64'd0);
        chk("rst.id_valid", 64'(id_valid), 64'd0);
        chk("rst.id_instr", 64'(id_instr), 64'd0);
        chk("rst.id_pc", id_pc, 64'd0);
        nxt();

        // Basic fetch of one instruction
        rst_n = 1'b1;
        drv(64'h1000, 1'b1, 1'b0, 32'h0, 1'b1, 1'b0, 64'h0); #2;
        chk("t1.req_valid", 64'(mem_req_valid), 64'd1);
        chk("t1.req_addr", mem_req_addr, 64'h1000);
        chk("t1.pc_load", 64'(pc_load), 64'd1);
        chk("t1.pc_next", pc_next, 64'h1004);
        nxt();
        drv(64'h1004, 1'b0, 1'b1, 32'h0000_0013, 1'b1, 1'b0, 64'h0); #2;
        chk("t1.wait_no_req", 64'(mem_req_valid), 64'd0);
        nxt();
        drv(64'h1004, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 64'h0); #2;
        chk("t1.id_valid", 64'(id_valid), 64'd1);
        chk("t1.id_instr", 64'(id_instr), 64'h13);
        chk("t1.id_pc", id_pc, 64'h1000);
        nxt();
        drv(64'h1004, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 64'h0); nxt();

        // Fill the buffer with decode stalled
        drv(64'h2000, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 64'h0); nxt();
        drv(64'h2004, 1'b1, 1'b1, 32'hA0, 1'b0, 1'b0, 64'h0); nxt();
        drv(64'h2004, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 64'h0); nxt();
        drv(64'h2008, 1'b1, 1'b1, 32'hA4, 1'b0, 1'b0, 64'h0); nxt();
        drv(64'h2008, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 64'h0); #2;
        chk("t2.full_no_req", 64'(mem_req_valid), 64'd0);
        chk("t2.head_pc", id_pc, 64'h2000);
        nxt();
        drv(64'h2008, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 64'h0); #2;
        chk("t2.full_hold", 64'(mem_req_valid), 64'd0);
        nxt();
        drv(64'h2008, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 64'h0); #2;
        chk("t2.pop0_pc", id_pc, 64'h2000);
        chk("t2.pop0_ins", 64'(id_instr), 64'hA0);
        nxt();
        drv(64'h2008, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 64'h0); #2;
        chk("t2.pop1_pc", id_pc, 64'h2004);
        chk("t2.pop1_ins", 64'(id_instr), 64'hA4);
        nxt();

        // Redirect while waiting; stale response must vanish
        drv(64'h3000, 1'b1, 1'b0, 32'h0, 1'b1, 1'b0, 64'h0); #2;
        chk("t3.req_addr", mem_req_addr, 64'h3000);
        nxt();
        drv(64'h3004, 1'b1, 1'b0, 32'h0, 1'b1, 1'b1, 64'h8000); #2;
        chk("t3.redir_load", 64'(pc_load), 64'd1);
        chk("t3.redir_next", pc_next, 64'h8000);
        nxt();
        drv(64'h8000, 1'b1, 1'b0, 32'h0, 1'b1, 1'b0, 64'h0); #2;
        chk("t3.drop_no_req", 64'(mem_req_valid), 64'd0);
        nxt();
        drv(64'h8000, 1'b1, 1'b1, 32'hDEAD_0013, 1'b1, 1'b0, 64'h0); #2;
        chk("t3.drop_rsp_no_req", 64'(mem_req_valid), 64'd0);
        nxt();
        drv(64'h8000, 1'b1, 1'b0, 32'h0, 1'b1, 1'b0, 64'h0); #2;
        chk("t3.refetch_valid", 64'(mem_req_valid), 64'd1);
        chk("t3.refetch_addr", mem_req_addr, 64'h8000);
        chk("t3.no_stale", 64'(id_valid), 64'd0);
        nxt();
        drv(64'h8004, 1'b0, 1'b1, 32'h55, 1'b1, 1'b0, 64'h0); nxt();
        drv(64'h8004, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 64'h0); #2;
        chk("t3.new_pc", id_pc, 64'h8000);
        nxt();

        // PC wrap-around and unaligned address masking
        drv(64'hFFFF_FFFF_FFFF_FFFC, 1'b1, 1'b0, 32'h0, 1'b1, 1'b0, 64'h0); #2;
        chk("t4.pc_load", 64'(pc_load), 64'd1);
        chk("t4.pc_next_wrap", pc_next, 64'h0);
        nxt();
        drv(64'h0, 1'b0, 1'b1, 32'h77, 1'b1, 1'b0, 64'h0); nxt();
        drv(64'h0, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 64'h0); #2;
        chk("t4.id_pc", id_pc, 64'hFFFF_FFFF_FFFF_FFFC);
        nxt();
        drv(64'h6006, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 64'h0); #2;
        chk("t4.addr_align", mem_req_addr, 64'h6004);
        nxt();

        // Redirect coinciding with response and pop
        drv(64'h4000, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 64'h0); nxt();
        drv(64'h4004, 1'b0, 1'b1, 32'h41, 1'b0, 1'b0, 64'h0); nxt();
        drv(64'h4004, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 64'h0); nxt();
        drv(64'h4008, 1'b0, 1'b1, 32'h42, 1'b1, 1'b1, 64'h9000); #2;
        chk("t5.pc_load", 64'(pc_load), 64'd1);
        chk("t5.pc_next", pc_next, 64'h9000);
        chk("t5.pop_pc", id_pc, 64'h4000);
        nxt();
        drv(64'h9000, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 64'h0); #2;
        chk("t5.flushed", 64'(id_valid), 64'd0);
        chk("t5.fetch_state", 64'(mem_req_valid), 64'd1);
        chk("t5.addr", mem_req_addr, 64'h9000);
        nxt();

        // Asynchronous reset while waiting with a buffered entry
        drv(64'h5000, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 64'h0); nxt();
        drv(64'h5004, 1'b0, 1'b1, 32'h50, 1'b0, 1'b0, 64'h0); nxt();
        drv(64'h5004, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 64'h0); nxt();
        drv(64'h5008, 1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 64'hA000); #1;
        rst_n = 1'b0; #1;
        chk("t6.rst_req_valid", 64'(mem_req_valid), 64'd0);
        chk("t6.rst_pc_load", 64'(pc_load), 64'd0);
        chk("t6.rst_id_valid", 64'(id_valid), 64'd0);
        chk("t6.rst_id_pc", id_pc, 64'd0);
        nxt();
        drv(64'h5000, 1'b1, 1'b1, 32'hBAD, 1'b1, 1'b0, 64'h0); nxt();
        rst_n = 1'b1;
        drv(64'h5000, 1'b1, 1'b0, 32'h0, 1'b1, 1'b0, 64'h0); #2;
        chk("t6.restart_valid", 64'(mem_req_valid), 64'd1);
        chk("t6.restart_addr", mem_req_addr, 64'h5000);
        nxt();
        drv(64'h5004, 1'b0, 1'b1, 32'h66, 1'b1, 1'b0, 64'h0); nxt();
        drv(64'h5004, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 64'h0); #2;
        chk("t6.after_pc", id_pc, 64'h5000);
        chk("t6.after_ins", 64'(id_instr), 64'h66);
        nxt();
        nxt();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
